text_buffer: RTL and testbench

Character-cell store and scan-address generator for the 70×30 text-mode VGA terminal. Accepts ASCII codes from the keyboard decoder and maintains the write pointer, applying backspace, newline and wrap-clear. Converts the VGA controller's pixel coordinates into cell/glyph coordinates. Feeds the glyph-template ROM stage directly with `ascii`, `char_h`, `char_v`, `ascii_v`, `raddr` and `waddr`.

---
 rtl/text_pkg.sv | 27 ++
 rtl/text_ram.sv | 41 ++++
 rtl/text_buffer.sv | 188 ++++++++++++++++++
 tb/tb_text_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
`default_nettype none
// ============================================================================
// Module      : text_pkg
// Description : Shared geometry, control codes and FSM state encoding for the
//               70x30 text-mode character buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package text_pkg;

    localparam int COLS   = 70;
    localparam int ROWS   = 30;
    localparam int CELLS  = COLS * ROWS;
    localparam int CHAR_W = 9;
    localparam int CHAR_H = 16;

    localparam logic [7:0] ASCII_BS     = 8'h08;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_CURSOR = 8'h5F;

    // CLEAR sweeps the whole store; IDLE accepts keyboard codes.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/text_ram.sv
`default_nettype none
// ============================================================================
// Module      : text_ram
// Description : Simple dual-port character RAM. One write port, one
//               synchronous read port; a read of a cell being written in the
//               same cycle returns the previous contents.
// Revision    : 1.0 - initial release
// ============================================================================
module text_ram #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [2**AW];

    // Write port: keyboard character or clear sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port: registered, samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/text_buffer.sv
`default_nettype none
// ============================================================================
// Module      : text_buffer
// Description : Character-cell store for the text terminal. Tracks the write
//               pointer (printable, newline, backspace, wrap-and-clear) and
//               turns VGA pixel coordinates into cell/glyph coordinates plus
//               the character code at that cell, one cycle later.
// Options     : TEXT_CURSOR_EN - blinking '_' cursor at the write pointer,
//               driven by a 6-bit frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module text_buffer #(
    parameter int COLS   = 70,
    parameter int ROWS   = 30,
    parameter int CHAR_W = 9,
    parameter int CHAR_H = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kb_valid,
    input  logic [7:0] kb_ascii,
    output logic       kb_ready,
    input  logic [9:0] h_addr,
    input  logic [9:0] v_addr,
    output logic [7:0] ascii,
    output logic [3:0] char_h,
    output logic [3:0] char_v,
    output logic [7:0] ascii_v,
    output logic [11:0] raddr,
    output logic [11:0] waddr
);

    import text_pkg::*;

    localparam logic [11:0] c_last_cell = 12'(ROWS * COLS - 1);
    localparam logic [6:0]  c_last_col  = 7'(COLS - 1);
    localparam logic [4:0]  c_last_row  = 5'(ROWS - 1);

    state_t      r_state, w_state_nxt;
    logic [4:0]  r_wrow, w_wrow_nxt;
    logic [6:0]  r_wcol, w_wcol_nxt;
    logic [11:0] r_clr_addr, w_clr_nxt;
    logic        w_we;
    logic [11:0] w_wr_addr;
    logic [7:0]  w_wr_data;
    logic [11:0] w_waddr;
    logic        w_consume;
    logic        w_adv_row;

    logic [7:0]  w_col;
    logic [3:0]  w_cv;
    logic [3:0]  w_ch;
    logic [11:0] w_row;
    logic [11:0] w_scan_addr;
    logic [7:0]  w_ram_q;

    assign w_waddr   = 12'(r_wrow) * 12'(COLS) + 12'(r_wcol);
    assign waddr     = w_waddr;
    assign kb_ready  = (r_state == IDLE);
    assign w_consume = kb_valid && kb_ready;
    assign w_adv_row = (kb_ascii == ASCII_LF) || (r_wcol == c_last_col);

    // State and pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_wrow     <= '0;
            r_wcol     <= '0;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wrow     <= w_wrow_nxt;
            r_wcol     <= w_wcol_nxt;
            r_clr_addr <= w_clr_nxt;
        end
    end

    // Next-state, pointer update and RAM write request.
    always_comb begin
        w_state_nxt = r_state;
        w_wrow_nxt  = r_wrow;
        w_wcol_nxt  = r_wcol;
        w_clr_nxt   = r_clr_addr;
        w_we        = 1'b0;
        w_wr_addr   = w_waddr;
        w_wr_data   = 8'h00;
        case (r_state)
            CLEAR: begin
                w_we      = 1'b1;
                w_wr_addr = r_clr_addr;
                if (r_clr_addr == c_last_cell) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_clr_nxt = r_clr_addr + 12'd1;
                end
            end
            IDLE: begin
                if (w_consume) begin
                    if (kb_ascii == ASCII_BS) begin
                        // Backspace at the origin is swallowed without effect.
                        if (w_waddr != 12'd0) begin
                            w_we      = 1'b1;
                            w_wr_addr = w_waddr - 12'd1;
                            if (r_wcol == 7'd0) begin
                                w_wrow_nxt = r_wrow - 5'd1;
                                w_wcol_nxt = c_last_col;
                            end else begin
                                w_wcol_nxt = r_wcol - 7'd1;
                            end
                        end
                    end else begin
                        // Printable and newline both store the code itself.
                        w_we      = 1'b1;
                        w_wr_data = kb_ascii;
                        if (w_adv_row) begin
                            w_wcol_nxt = 7'd0;
                            if (r_wrow == c_last_row) begin
                                w_wrow_nxt  = 5'd0;
                                w_clr_nxt   = 12'd0;
                                w_state_nxt = CLEAR;
                            end else begin
                                w_wrow_nxt = r_wrow + 5'd1;
                            end
                        end else begin
                            w_wcol_nxt = r_wcol + 7'd1;
                        end
                    end
                end
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

    // Scan coordinate decode; the read address feeds the RAM unregistered so
    // the RAM output lines up with the registered coordinates.
    assign w_col       = 8'(h_addr / 10'(CHAR_W));
    assign w_cv        = 4'(h_addr % 10'(CHAR_W));
    assign w_ch        = 4'(v_addr % 10'(CHAR_H));
    assign w_row       = 12'(v_addr / 10'(CHAR_H));
    assign w_scan_addr = w_row * 12'(COLS) + 12'(w_col);

    // Scan output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ascii_v <= '0;
            char_v  <= '0;
            char_h  <= '0;
            raddr   <= '0;
        end else begin
            ascii_v <= w_col;
            char_v  <= w_cv;
            char_h  <= w_ch;
            raddr   <= w_scan_addr;
        end
    end

    text_ram #(
        .AW (12),
        .DW (8)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we && !rst),
        .waddr (w_wr_addr),
        .wdata (w_wr_data),
        .raddr (w_scan_addr),
        .rdata (w_ram_q)
    );

`ifdef TEXT_CURSOR_EN
    logic [5:0] r_frame;

    // Frame counter ticks once per frame origin; bit 5 sets the blink phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame <= '0;
        end else if (h_addr == 10'd0 && v_addr == 10'd0) begin
            r_frame <= r_frame + 6'd1;
        end
    end

    assign ascii = (r_frame[5] && raddr == w_waddr) ? ASCII_CURSOR : w_ram_q;
`else
    assign ascii = w_ram_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_text_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_buffer
// Description : Directed self-checking bench for text_buffer: reset/clear
//               timing, write pointer handling, scan decode and wrap-clear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        kb_valid;
    logic [7:0]  kb_ascii;
    logic        kb_ready;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic [7:0]  ascii;
    logic [3:0]  char_h;
    logic [3:0]  char_v;
    logic [7:0]  ascii_v;
    logic [11:0] raddr;
    logic [11:0] waddr;

    int n_vec  = 0;
    int n_err  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    text_buffer u_dut (
        .clk      (clk),
        .rst      (rst),
        .kb_valid (kb_valid),
        .kb_ascii (kb_ascii),
        .kb_ready (kb_ready),
        .h_addr   (h_addr),
        .v_addr   (v_addr),
        .ascii    (ascii),
        .char_h   (char_h),
        .char_v   (char_v),
        .ascii_v  (ascii_v),
        .raddr    (raddr),
        .waddr    (waddr)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts negedges with kb_ready low, starting at the current one.
    task automatic wait_clear(output int n);
        n = 0;
        while (!kb_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] c);
        if (!kb_ready) n_miss++;
        kb_valid = 1'b1;
        kb_ascii = c;
        @(negedge clk);
        kb_valid = 1'b0;
    endtask

    task automatic read_cell(input int a, output logic [7:0] q);
        h_addr = 10'((a % 70) * 9);
        v_addr = 10'((a / 70) * 16);
        @(negedge clk);
        q = ascii;
    endtask

    task automatic check_all_zero(input string tag);
        logic [7:0] q;
        int nz;
        nz = 0;
        for (int a = 0; a < 2100; a++) begin
            read_cell(a, q);
            if (q !== 8'h00) nz++;
        end
        check_val(tag, nz, 0);
    endtask

    function automatic logic [7:0] code_of(input int i);
        return 8'(8'h30 + (i % 40));
    endfunction

    initial begin
        int n;
        logic [7:0] q;
        rst      = 1'b1;
        kb_valid = 1'b0;
        kb_ascii = 8'h00;
        h_addr   = 10'd100;
        v_addr   = 10'd50;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_ready", kb_ready, 0);
        check_val("rst_waddr", waddr, 0);
        check_val("rst_raddr", raddr, 0);
        check_val("rst_ascii_v", ascii_v, 0);
        check_val("rst_char_v", char_v, 0);
        check_val("rst_char_h", char_h, 0);

        // Interrupt the clear part-way; it must restart from cell 0.
        rst = 1'b0;
        repeat (500) @(negedge clk);
        check_val("midclr_ready", kb_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_clear(n);
        check_val("clear_len", n, 2100);
        check_val("post_clr_waddr", waddr, 0);
        check_all_zero("cells_zero");

        // Backspace at the origin.
        send(8'h08);
        check_val("bs0_waddr", waddr, 0);
        check_val("bs0_ready", kb_ready, 1);

        // Two characters, then scan the second one.
        send(8'h41);
        send(8'h42);
        check_val("ab_waddr", waddr, 2);
        h_addr = 10'd9;
        v_addr = 10'd3;
        @(negedge clk);
        check_val("scan_ascii", ascii, 8'h42);
        check_val("scan_ascii_v", ascii_v, 1);
        check_val("scan_char_v", char_v, 0);
        check_val("scan_char_h", char_h, 3);
        check_val("scan_raddr", raddr, 1);
        h_addr = 10'd13;
        v_addr = 10'd19;
        @(negedge clk);
        check_val("scan2_ascii_v", ascii_v, 1);
        check_val("scan2_char_v", char_v, 4);
        check_val("scan2_char_h", char_h, 3);
        check_val("scan2_raddr", raddr, 71);
        h_addr = 10'd635;
        v_addr = 10'd479;
        @(negedge clk);
        check_val("edge_ascii_v", ascii_v, 70);
        check_val("edge_char_v", char_v, 5);
        check_val("edge_char_h", char_h, 15);
        check_val("edge_raddr", raddr, 2100);

        // Read and write of cell 2 in the same cycle returns old data.
        h_addr   = 10'd18;
        v_addr   = 10'd0;
        kb_valid = 1'b1;
        kb_ascii = 8'h43;
        @(negedge clk);
        kb_valid = 1'b0;
        check_val("rbw_old", ascii, 8'h00);
        @(negedge clk);
        check_val("rbw_new", ascii, 8'h43);

        // Newline then backspace across the row boundary.
        send(8'h44);
        send(8'h45);
        check_val("five_waddr", waddr, 5);
        send(8'h0A);
        check_val("lf_waddr", waddr, 70);
        read_cell(5, q);
        check_val("lf_cell5", q, 8'h0A);
        read_cell(4, q);
        check_val("cell4", q, 8'h45);
        send(8'h08);
        check_val("bs_row_waddr", waddr, 69);
        send(8'h5A);
        check_val("col69_waddr", waddr, 70);
        read_cell(69, q);
        check_val("cell69_z", q, 8'h5A);
        send(8'h08);
        check_val("bs2_waddr", waddr, 69);
        read_cell(69, q);
        check_val("bs_cell69", q, 8'h00);

`ifdef TEXT_CURSOR_EN
        begin
            int on_cnt;
            int other_cnt;
            on_cnt    = 0;
            other_cnt = 0;
            for (int f = 0; f < 64; f++) begin
                h_addr = 10'd0;
                v_addr = 10'd0;
                @(negedge clk);
                read_cell(69, q);
                if (q == 8'h5F) on_cnt++;
                read_cell(4, q);
                if (q != 8'h45) other_cnt++;
            end
            check_val("cursor_on", on_cnt, 32);
            check_val("cursor_other", other_cnt, 0);
        end
`endif

        // Fill to the last cell; the final code triggers wrap-and-clear.
        for (int i = 0; i < 2031; i++) begin
            send(code_of(i));
            if (i == 930) check_val("fill_waddr", waddr, 1000);
        end
        check_val("wrap_waddr", waddr, 0);
        check_val("wrap_ready", kb_ready, 0);
        h_addr = 10'd621;
        v_addr = 10'd464;
        @(negedge clk);
        check_val("wrap_last", ascii, code_of(2030));
        wait_clear(n);
        check_val("wrap_clear_len", n + 1, 2100);
        check_val("wrap_post_waddr", waddr, 0);
        check_all_zero("wrap_cells_zero");
        check_val("ready_misses", n_miss, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
